upg_loader: RTL

- UART program-load sequencer that drives the UPG write port of the instruction ROM and data RAM.
- Consumes the byte stream from the UART receiver, parses a small header, and assembles little-endian 32-bit words.
- Issues one-cycle UPG write strobes with word address and data, validates an XOR checksum, then raises upg_done_o so the memories return to CPU mode.

---
 rtl/upg_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/upg_loader.sv
// UART program loader: parses target/count header, assembles LE words,
// drives the UPG write port and verifies the XOR checksum.
module upg_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W:0]   upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0] MAX_CNT = 17'd1 << ADDR_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TGT   = 3'd1;
  localparam logic [2:0] S_CNT0  = 3'd2;
  localparam logic [2:0] S_CNT1  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;

  logic [2:0]        state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       buf_q, buf_d;
  logic [7:0]        csum_q, csum_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wen_q, wen_d;
  logic [ADDR_W:0]   adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;

  logic        busy;
  logic [15:0] cnt_full;
  logic        last_word;

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE)
             && (state_q != S_ERROR);
  assign cnt_full  = {rx_data_i, cnt_q[7:0]};
  assign last_word = (17'(widx_q) + 17'd1) == {1'b0, cnt_q};

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    buf_d   = buf_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;

    // Watchdog between bytes; any accepted byte rearms it.
    if (busy) begin
      if (rx_valid_i) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        state_d = S_ERROR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_TGT;
          csum_d  = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      S_TGT: begin
        if (rx_valid_i) begin
          csum_d = csum_q ^ rx_data_i;
          if (rx_data_i == 8'h00 || rx_data_i == 8'h01) begin
            tgt_d   = rx_data_i[0];
            state_d = S_CNT0;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_CNT0: begin
        if (rx_valid_i) begin
          csum_d     = csum_q ^ rx_data_i;
          cnt_d[7:0] = rx_data_i;
          state_d    = S_CNT1;
        end
      end
      S_CNT1: begin
        if (rx_valid_i) begin
          csum_d = csum_q ^ rx_data_i;
          cnt_d  = cnt_full;
          if ({1'b0, cnt_full} > MAX_CNT) begin
            state_d = S_ERROR;
          end else if (cnt_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid_i) begin
          csum_d = csum_q ^ rx_data_i;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d  = 1'b1;
            adr_d  = {tgt_q, widx_q};
            dat_d  = {rx_data_i, buf_q};
            widx_d = widx_q + 1'b1;
            if (last_word) begin
              state_d = S_CSUM;
            end
          end else begin
            buf_d[8*bcnt_q +: 8] = rx_data_i;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid_i) begin
          state_d = (rx_data_i == csum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      buf_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      buf_q   <= buf_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign busy_o     = busy;
  assign upg_done_o = (state_q == S_DONE);
  assign err_o      = (state_q == S_ERROR);

endmodule
